// File: rtl/an_barrett_reduce_n13.sv
// an_barrett_reduce_n13: 3-stage Barrett reduction of an AN (A=13) codeword into quotient mod 2^W_Q and residue,
// with valid/ready handshaking and a saturating count of words delivered with a nonzero residue.
module an_barrett_reduce_n13 #(
   parameter int A      = 13,
   parameter int W_CODE = 7,
   parameter int W_Q    = 3,
   parameter int W_R    = 4,
   parameter int K      = 10,
   parameter int M      = 78,
   parameter int W_CNT  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W_CODE-1:0] in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W_Q-1:0]    out_quotient,
   output logic [W_R-1:0]    out_residue,
   output logic              out_err,
   output logic [W_CNT-1:0]  err_count,
   input  logic              cnt_clear
);
   localparam int W_P  = W_CODE + 7;
   localparam int W_QE = W_P - K;
   localparam int W_RR = 5;

   logic              s1_valid, s2_valid;
   logic [W_CODE-1:0] s1_y;
   logic [W_P-1:0]    s1_p;
   logic [W_QE-1:0]   s2_q, q_est, q_fix;
   logic [W_RR-1:0]   s2_r, r_fix;
   logic              out_adv, s2_adv, s1_adv, corr;

   assign out_adv  = !out_valid | out_ready;
   assign s2_adv   = s2_valid & out_adv;
   assign s1_adv   = s1_valid & (!s2_valid | s2_adv);
   assign in_ready = !s1_valid | s1_adv;
   assign q_est    = W_QE'(s1_p >> K);
   // Barrett estimate is at most one short, so a single conditional subtract finishes the reduction
   assign corr     = s2_r >= W_RR'(A);
   assign q_fix    = s2_q + W_QE'(corr);
   assign r_fix    = s2_r - (corr ? W_RR'(A) : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid     <= 1'b0;
         s1_y         <= '0;
         s1_p         <= '0;
         s2_valid     <= 1'b0;
         s2_q         <= '0;
         s2_r         <= '0;
         out_valid    <= 1'b0;
         out_quotient <= '0;
         out_residue  <= '0;
         out_err      <= 1'b0;
         err_count    <= '0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_y <= in_code;
               s1_p <= W_P'(in_code) * W_P'(M);
            end
         end
         if (!s2_valid | s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_q <= q_est;
               s2_r <= W_RR'(s1_y) - W_RR'(A) * W_RR'(q_est);
            end
         end
         if (out_adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
               out_quotient <= W_Q'(q_fix);
               out_residue  <= W_R'(r_fix);
               out_err      <= r_fix != '0;
            end
         end
         if (cnt_clear)
            err_count <= '0;
         else if (out_valid & out_ready & out_err & ~&err_count)
            err_count <= err_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_an_barrett_reduce_n13.sv
// tb_an_barrett_reduce_n13: randomized and directed checks of the Barrett stage against a y/13, y%13 reference model.
module tb_an_barrett_reduce_n13;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_err, cnt_clear;
   logic [6:0]  in_code;
   logic [2:0]  out_quotient;
   logic [3:0]  out_residue;
   logic [15:0] err_count;

   int          errors = 0;
   int          checks = 0;
   int          exp_q[$];
   logic [15:0] mcnt = '0;
   logic        held_v = 1'b0;
   logic [2:0]  held_q;
   logic [3:0]  held_r;
   logic        held_e;
   logic        rnd_done = 1'b0;

   an_barrett_reduce_n13 dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
      .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
      .out_residue(out_residue), .out_err(out_err), .err_count(err_count), .cnt_clear(cnt_clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: the rules of the reduction applied to every word crossing the output handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         mcnt   = '0;
         held_v = 1'b0;
      end else begin
         chk("cnt", 32'(err_count), 32'(mcnt));
         if (held_v) begin
            chk("hold_v", 32'(out_valid), 1);
            chk("hold_q", 32'(out_quotient), 32'(held_q));
            chk("hold_r", 32'(out_residue), 32'(held_r));
            chk("hold_e", 32'(out_err), 32'(held_e));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else begin
               int y;
               y = exp_q.pop_front();
               chk("res", 32'(out_residue), y % 13);
               chk("quo", 32'(out_quotient), (y / 13) % 8);
               chk("err", 32'(out_err), 32'(y % 13 != 0));
               if (y == 13) chk("y13", {out_quotient, out_residue}, {3'd1, 4'd0});
               if (y == 127) chk("y127", {out_quotient, out_residue}, {3'd1, 4'd10});
               if (y == 91) chk("y91", {out_quotient, out_residue}, {3'd7, 4'd0});
               if (cnt_clear) mcnt = '0;
               else if (y % 13 != 0 && mcnt != 16'hffff) mcnt = mcnt + 1'b1;
            end
         end else if (cnt_clear) mcnt = '0;
         if (in_valid && in_ready) exp_q.push_back(int'(in_code));
         held_v = out_valid && !out_ready;
         held_q = out_quotient;
         held_r = out_residue;
         held_e = out_err;
      end
   end

   task automatic send(input logic [6:0] y);
      logic acc;
      in_valid = 1'b1;
      in_code  = y;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         if (i == 999) chk("send_timeout", 0, 1);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
   endtask

   initial begin
      int n;
      rst_n = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; cnt_clear = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ov", 32'(out_valid), 0);
      chk("rst_ir", 32'(in_ready), 1);
      chk("rst_cnt", 32'(err_count), 0);
      chk("rst_qre", {out_quotient, out_residue, out_err}, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(7'd45);
      wait_out(n);
      chk("lat45", n, 3);
      chk("q45", 32'(out_quotient), 3);
      chk("r45", 32'(out_residue), 6);
      chk("e45", 32'(out_err), 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("cnt45", 32'(err_count), 1);
      for (int y = 0; y < 128; y++) send(7'(y));
      drain();
      out_ready = 1'b0;
      fork
         for (int i = 0; i < 10; i++) send(7'(i * 11 + 3));
         begin
            repeat (5) @(negedge clk);
            chk("bp_ready_low", 32'(in_ready), 0);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               logic [6:0] y;
               y = 7'(13 * $urandom_range(0, 9));
               if ($urandom_range(0, 1) == 1) y = y ^ (7'd1 << $urandom_range(0, 6));
               if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(posedge clk);
               #1 send(y);
            end
            rnd_done = 1'b1;
         end
         while (!rnd_done) begin
            @(posedge clk);
            #1 out_ready = $urandom_range(0, 3) != 0;
         end
      join
      drain();
      force dut.err_count = 16'hfffe;
      mcnt = 16'hfffe;
      @(posedge clk);
      #1 release dut.err_count;
      for (int i = 0; i < 3; i++) send(7'd1);
      drain();
      chk("sat", 32'(err_count), 32'hffff);
      out_ready = 1'b0;
      send(7'd1);
      wait_out(n);
      chk("clr_ov", 32'(out_valid), 1);
      @(posedge clk);
      #1;
      cnt_clear = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 cnt_clear = 1'b0;
      @(negedge clk);
      chk("clr", 32'(err_count), 0);
      send(7'd5);
      drain();
      out_ready = 1'b0;
      send(7'd1); send(7'd2); send(7'd3);
      chk("pre_rst_ov", 32'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ov", 32'(out_valid), 0);
      chk("mid_rst_cnt", 32'(err_count), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      send(7'd26);
      wait_out(n);
      chk("lat26", n, 3);
      chk("q26", 32'(out_quotient), 2);
      chk("r26", 32'(out_residue), 0);
      chk("e26", 32'(out_err), 0);
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
